// File: rtl/pe_mem_pkg.sv
// Shared encodings for the PE memory responder: FSM states, data width, operand selects.
// Optional misalignment check is enabled by defining PE_MEM_ALIGN_CHECK_EN.
package pe_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = 4'd1;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/pe_mem_array.sv
// Single-port synchronous word storage with registered read data; contents are never cleared.
module pe_mem_array
    import pe_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem_r [2**DEPTH_LOG2];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read of the currently addressed word.
    always_ff @(posedge clk) begin
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/pe_mem_responder.sv
// Memory-side responder for one CGRA PE load/store port: capture, fixed-latency wait, ack, operand steering.
// Define PE_MEM_ALIGN_CHECK_EN to flag misaligned accesses (writes dropped, reads return zero).
module pe_mem_responder
    import pe_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] write_data,
    input  logic        reg_select,
    output logic        mem_ack,
    output logic        data_Ready,
    output logic [31:0] AmuxIn,
    output logic [31:0] BmuxIn,
    output logic        align_err
);

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [WORD_W-1:0] addr_r, wdata_r, rdata_s, load_data_s;
    logic              sel_r, is_wr_r, req_s, misaligned_s, we_s;
    logic              ack_nxt_s, rdy_nxt_s, err_nxt_s;
    logic [WORD_W-1:0] a_nxt_s, b_nxt_s;
    logic              mem_ack_r, data_ready_r, align_err_r;
    logic [WORD_W-1:0] a_r, b_r;
    logic              unused_addr_s;

    assign req_s = mem_read | mem_write;

`ifdef PE_MEM_ALIGN_CHECK_EN
    assign misaligned_s  = is_misaligned(addr_r[1:0]);
    assign unused_addr_s = ^addr_r[WORD_W-1:DEPTH_LOG2+2];
`else
    assign misaligned_s  = 1'b0;
    assign unused_addr_s = ^{addr_r[WORD_W-1:DEPTH_LOG2+2], addr_r[1:0]};
`endif

    assign load_data_s = misaligned_s ? 32'h0000_0000 : rdata_s;

    pe_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk   (clk),
        .we    (we_s),
        .addr  (addr_r[DEPTH_LOG2+1:2]),
        .wdata (wdata_r),
        .rdata (rdata_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request capture and latency counter; later request changes are ignored until DRAIN clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            sel_r   <= SEL_A;
            is_wr_r <= 1'b0;
        end else if (state_r == ST_IDLE && req_s) begin
            cnt_r   <= CNT_W'(LATENCY);
            addr_r  <= mem_address;
            wdata_r <= write_data;
            sel_r   <= reg_select;
            is_wr_r <= mem_write;
        end else if (state_r == ST_BUSY && cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = req_s ? ST_BUSY : ST_IDLE;
            ST_BUSY:  state_nxt_s = (cnt_r == '0) ? ST_RESP : ST_BUSY;
            ST_RESP:  state_nxt_s = ST_DRAIN;
            ST_DRAIN: state_nxt_s = req_s ? ST_DRAIN : ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Response decode: next values for the registered handshake/data outputs and the write strobe.
    always_comb begin
        ack_nxt_s = 1'b0;
        rdy_nxt_s = 1'b0;
        we_s      = 1'b0;
        a_nxt_s   = a_r;
        b_nxt_s   = b_r;
        err_nxt_s = align_err_r;
        if (state_r == ST_RESP) begin
            ack_nxt_s = 1'b1;
            err_nxt_s = align_err_r | misaligned_s;
            if (is_wr_r) begin
                we_s = ~misaligned_s;
            end else begin
                rdy_nxt_s = 1'b1;
                if (sel_r == SEL_B) begin
                    b_nxt_s = load_data_s;
                end else begin
                    a_nxt_s = load_data_s;
                end
            end
        end else begin
            ack_nxt_s = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ack_r    <= 1'b0;
            data_ready_r <= 1'b0;
            a_r          <= '0;
            b_r          <= '0;
            align_err_r  <= 1'b0;
        end else begin
            mem_ack_r    <= ack_nxt_s;
            data_ready_r <= rdy_nxt_s;
            a_r          <= a_nxt_s;
            b_r          <= b_nxt_s;
            align_err_r  <= err_nxt_s;
        end
    end

    assign mem_ack    = mem_ack_r;
    assign data_Ready = data_ready_r;
    assign AmuxIn     = a_r;
    assign BmuxIn     = b_r;
    assign align_err  = align_err_r;

endmodule

// File: tb/tb_pe_mem_responder.sv
// Self-checking bench for pe_mem_responder with a scoreboard of expected responses.
// Follows PE_MEM_ALIGN_CHECK_EN when it is defined for the build.
module tb_pe_mem_responder;

    localparam int LAT = 2;
`ifdef PE_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_address;
    logic        mem_read, mem_write, reg_select;
    logic [31:0] write_data;
    logic        mem_ack, data_Ready, align_err;
    logic [31:0] AmuxIn, BmuxIn;

    pe_mem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .write_data  (write_data),
        .reg_select  (reg_select),
        .mem_ack     (mem_ack),
        .data_Ready  (data_Ready),
        .AmuxIn      (AmuxIn),
        .BmuxIn      (BmuxIn),
        .align_err   (align_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [int];
    logic [31:0] model_a, model_b;
    int          total = 0;
    int          bad = 0;

    int          obs_lat, obs_extra;
    logic        obs_rdy;
    logic [31:0] obs_a, obs_b;

    // Drive one request from a negedge, push the model's expectation, wait for ack, then release.
    task automatic transact(input logic [31:0] addr, input logic rd, input logic wr,
                            input logic [31:0] wd, input logic sel, input int hold);
        exp_t e;
        int   edges;
        int   idx;
        logic mis;
        idx = int'((addr >> 2) & 32'h0000_00FF);
        mis = ALIGN && (addr[1:0] != 2'b00);
        e.rdy = 1'b0;
        if (wr) begin
            if (!mis) mem_m[idx] = wd;
        end else begin
            e.rdy = 1'b1;
            if (sel) model_b = mis ? 32'h0 : mem_m[idx];
            else     model_a = mis ? 32'h0 : mem_m[idx];
        end
        e.a = model_a;
        e.b = model_b;
        sb.push_back(e);
        mem_address = addr; mem_read = rd; mem_write = wr; write_data = wd; reg_select = sel;
        edges = 0; obs_lat = -1; obs_extra = 0;
        while (edges < 40 && obs_lat < 0) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (mem_ack) obs_lat = edges - 1;
        end
        obs_rdy = data_Ready; obs_a = AmuxIn; obs_b = BmuxIn;
        mem_address = 32'hFFFF_FFFF; write_data = 32'h0BAD_0BAD; reg_select = ~sel;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            if (mem_ack) obs_extra++;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); @(negedge clk);
        if (mem_ack) obs_extra++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_address = 32'h0; mem_read = 1'b0; mem_write = 1'b0; write_data = 32'h0; reg_select = 1'b0;
        model_a = 32'h0; model_b = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if (mem_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got %b want 0", mem_ack); end
        total++; if (data_Ready !== 1'b0) begin bad++; $display("FAIL reset_rdy got %b want 0", data_Ready); end
        total++; if (AmuxIn !== 32'h0) begin bad++; $display("FAIL reset_a got %h want 0", AmuxIn); end
        total++; if (BmuxIn !== 32'h0) begin bad++; $display("FAIL reset_b got %h want 0", BmuxIn); end
        total++; if (align_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", align_err); end
    endtask

    task automatic test_write_read();
        exp_t e;
        transact(32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 0);
        e = sb.pop_front();
        total++; if (obs_lat != LAT + 2) begin bad++; $display("FAIL wr_latency got %0d want %0d", obs_lat, LAT + 2); end
        total++; if (obs_rdy !== e.rdy) begin bad++; $display("FAIL wr_rdy got %b want %b", obs_rdy, e.rdy); end
        transact(32'h10, 1'b1, 1'b0, 32'h0, 1'b1, 0);
        e = sb.pop_front();
        total++; if (obs_lat != LAT + 2) begin bad++; $display("FAIL rd_latency got %0d want %0d", obs_lat, LAT + 2); end
        total++; if (obs_rdy !== e.rdy) begin bad++; $display("FAIL rd_rdy got %b want %b", obs_rdy, e.rdy); end
        total++; if (obs_b !== e.b) begin bad++; $display("FAIL rd_b got %h want %h", obs_b, e.b); end
        total++; if (obs_a !== e.a) begin bad++; $display("FAIL rd_a_unchanged got %h want %h", obs_a, e.a); end
        total++; if (obs_extra != 0) begin bad++; $display("FAIL rd_single_ack got %0d extra want 0", obs_extra); end
    endtask

    task automatic test_held();
        exp_t e;
        transact(32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 10);
        e = sb.pop_front();
        total++; if (obs_extra != 0) begin bad++; $display("FAIL held_extra_acks got %0d want 0", obs_extra); end
        total++; if (obs_a !== e.a) begin bad++; $display("FAIL held_a got %h want %h", obs_a, e.a); end
        transact(32'h10, 1'b1, 1'b0, 32'h0, 1'b1, 0);
        e = sb.pop_front();
        total++; if (obs_lat != LAT + 2) begin bad++; $display("FAIL held_next_latency got %0d want %0d", obs_lat, LAT + 2); end
    endtask

    task automatic test_dual();
        exp_t e;
        transact(32'h20, 1'b1, 1'b1, 32'h5, 1'b0, 0);
        e = sb.pop_front();
        total++; if (obs_rdy !== e.rdy) begin bad++; $display("FAIL dual_rdy got %b want %b", obs_rdy, e.rdy); end
        total++; if (obs_a !== e.a || obs_b !== e.b) begin bad++; $display("FAIL dual_outputs got %h/%h want %h/%h", obs_a, obs_b, e.a, e.b); end
        transact(32'h20, 1'b1, 1'b0, 32'h0, 1'b0, 0);
        e = sb.pop_front();
        total++; if (obs_a !== e.a) begin bad++; $display("FAIL dual_readback got %h want %h", obs_a, e.a); end
    endtask

    task automatic test_wrap();
        exp_t e;
        transact(32'h400, 1'b0, 1'b1, 32'hA5, 1'b0, 0);
        void'(sb.pop_front());
        transact(32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 0);
        e = sb.pop_front();
        total++; if (obs_b !== e.b) begin bad++; $display("FAIL wrap_read got %h want %h", obs_b, e.b); end
    endtask

    task automatic test_abort();
        exp_t e;
        int   acks;
        transact(32'h30, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 0);
        void'(sb.pop_front());
        mem_address = 32'h30; mem_write = 1'b1; write_data = 32'h2222_2222;
        acks = 0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            if (mem_ack) acks++;
        end
        rst_n = 1'b0;
        #1;
        total++; if (acks != 0 || mem_ack !== 1'b0) begin bad++; $display("FAIL abort_ack got %0d/%b want 0/0", acks, mem_ack); end
        total++; if (AmuxIn !== 32'h0 || BmuxIn !== 32'h0) begin bad++; $display("FAIL abort_outputs got %h/%h want 0/0", AmuxIn, BmuxIn); end
        model_a = 32'h0; model_b = 32'h0;
        @(posedge clk); @(negedge clk);
        mem_write = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        transact(32'h30, 1'b1, 1'b0, 32'h0, 1'b0, 0);
        e = sb.pop_front();
        total++; if (obs_a !== e.a) begin bad++; $display("FAIL abort_no_write got %h want %h", obs_a, e.a); end
    endtask

    task automatic test_align();
        exp_t e;
        transact(32'h13, 1'b1, 1'b0, 32'h0, 1'b0, 0);
        e = sb.pop_front();
        total++; if (obs_lat != LAT + 2 || obs_rdy !== 1'b1) begin bad++; $display("FAIL align_handshake got %0d/%b want %0d/1", obs_lat, obs_rdy, LAT + 2); end
        total++; if (obs_a !== e.a) begin bad++; $display("FAIL align_data got %h want %h", obs_a, e.a); end
        total++; if (align_err !== ALIGN) begin bad++; $display("FAIL align_err got %b want %b", align_err, ALIGN); end
        transact(32'h22, 1'b0, 1'b1, 32'h7777_7777, 1'b0, 0);
        void'(sb.pop_front());
        transact(32'h20, 1'b1, 1'b0, 32'h0, 1'b1, 0);
        e = sb.pop_front();
        total++; if (obs_b !== e.b) begin bad++; $display("FAIL align_write_effect got %h want %h", obs_b, e.b); end
        total++; if (align_err !== ALIGN) begin bad++; $display("FAIL align_err_sticky got %b want %b", align_err, ALIGN); end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] wd;
        logic        sel;
        int          k;
        for (int i = 0; i < 8; i++) begin
            wd = $urandom;
            transact(32'h100 + 32'(i * 4), 1'b0, 1'b1, wd, 1'b0, 0);
            void'(sb.pop_front());
        end
        for (int i = 0; i < 8; i++) begin
            k = $urandom_range(0, 7);
            sel = 1'($urandom_range(0, 1));
            transact(32'h100 + 32'(k * 4), 1'b1, 1'b0, 32'h0, sel, 0);
            e = sb.pop_front();
            total++;
            if (obs_a !== e.a || obs_b !== e.b || obs_rdy !== 1'b1 || obs_lat != LAT + 2) begin
                bad++;
                $display("FAIL b2b_read%0d got a=%h b=%h rdy=%b lat=%0d want a=%h b=%h rdy=1 lat=%0d",
                         i, obs_a, obs_b, obs_rdy, obs_lat, e.a, e.b, LAT + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_held();
        test_dual();
        test_wrap();
        test_abort();
        test_align();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
